// File: rtl/uart_autobaud.sv
// Auto-baud acquisition: waits for line idle, times a 0x55 sync character on rxd
// and derives the receiver prescale word (bit time = 8 * prescale clocks).
module uart_autobaud #(
    parameter int unsigned CNT_WIDTH        = 22,
    parameter int unsigned IDLE_CYCLES      = 16,
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        start,
    output logic [15:0] prescale,
    output logic        locked,
    output logic        lock_pulse,
    output logic        error,
    output logic        busy
);

    localparam int unsigned SEG_W  = CNT_WIDTH - 3;
    localparam int unsigned SUM_W  = CNT_WIDTH + 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [SEG_W-1:0] SEG_MAX   = '1;
    localparam logic [SEG_W-1:0] MIN_FIRST = SEG_W'(8);
    localparam logic [2:0]       LAST_SEG  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_ARMED, S_MEASURE, S_DONE, S_FAIL
    } state_t;

    state_t r_state, w_state_nxt;

    logic                 r_sync1, r_rxd_s, r_rxd_prev;
    logic [IDLE_W-1:0]    r_idle_cnt, w_idle_cnt_nxt;
    logic [SEG_W-1:0]     r_seg_cnt,  w_seg_cnt_nxt;
    logic [SEG_W-1:0]     r_first,    w_first_nxt;
    logic [CNT_WIDTH-1:0] r_total,    w_total_nxt;
    logic [2:0]           r_seg_idx,  w_seg_idx_nxt;
    logic [15:0]          r_prescale, w_prescale_nxt;
    logic                 r_locked,   w_locked_nxt;
    logic                 r_lock_pulse, w_lock_pulse_nxt;
    logic                 r_error,    w_error_nxt;
    logic                 r_busy,     w_busy_nxt;

    logic             w_edge, w_fall, w_timeout, w_seg_bad, w_quot_ovf;
    logic [SEG_W-1:0] w_tol;
    logic [SEG_W:0]   w_lo, w_hi, w_seg_ext;
    logic [SUM_W-1:0] w_sum, w_quot;

    // Two-flop synchroniser plus one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_rxd_s    <= r_sync1;
            r_rxd_prev <= r_rxd_s;
        end
    end

    assign w_edge = r_rxd_s ^ r_rxd_prev;
    assign w_fall = r_rxd_prev & ~r_rxd_s;

    // Segment tolerance window is first +/- first/4, widened by one bit against overflow
    assign w_tol     = r_first >> 2;
    assign w_lo      = {1'b0, r_first} - {1'b0, w_tol};
    assign w_hi      = {1'b0, r_first} + {1'b0, w_tol};
    assign w_seg_ext = {1'b0, r_seg_cnt};
    assign w_seg_bad = (r_seg_idx == 3'd0) ? (r_seg_cnt < MIN_FIRST)
                                           : ((w_seg_ext < w_lo) || (w_seg_ext > w_hi));
    assign w_timeout = (r_seg_cnt == SEG_MAX);

    // Eight bit times measured, prescale = round(total / 64)
    assign w_sum      = {1'b0, r_total} + SUM_W'(32);
    assign w_quot     = w_sum >> 6;
    assign w_quot_ovf = (w_quot > SUM_W'(32'h0000_FFFF));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (!start && (r_idle_cnt == IDLE_W'(IDLE_CYCLES))) w_state_nxt = S_ARMED;
            S_ARMED: begin
                if (start)       w_state_nxt = S_WAIT_IDLE;
                else if (w_fall) w_state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                if (start)                       w_state_nxt = S_WAIT_IDLE;
                else if (w_edge && w_seg_bad)    w_state_nxt = S_FAIL;
                else if (w_edge && (r_seg_idx == LAST_SEG)) w_state_nxt = S_DONE;
                else if (!w_edge && w_timeout)   w_state_nxt = S_FAIL;
            end
            S_DONE, S_FAIL: w_state_nxt = start ? S_WAIT_IDLE : S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_idle_cnt_nxt   = r_idle_cnt;
        w_seg_cnt_nxt    = r_seg_cnt;
        w_first_nxt      = r_first;
        w_total_nxt      = r_total;
        w_seg_idx_nxt    = r_seg_idx;
        w_prescale_nxt   = r_prescale;
        w_locked_nxt     = r_locked;
        w_lock_pulse_nxt = 1'b0;
        w_error_nxt      = 1'b0;
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: if (start) w_locked_nxt = 1'b0;
            S_WAIT_IDLE: begin
                w_idle_cnt_nxt = r_rxd_s ? (r_idle_cnt + IDLE_W'(1)) : '0;
                // Preload the measurement so ARMED starts from a clean slate
                w_seg_cnt_nxt  = SEG_W'(1);
                w_total_nxt    = '0;
                w_seg_idx_nxt  = '0;
                w_first_nxt    = '0;
            end
            S_MEASURE: begin
                if (w_edge) begin
                    if (r_seg_idx == 3'd0) w_first_nxt = r_seg_cnt;
                    w_total_nxt   = r_total + CNT_WIDTH'(r_seg_cnt);
                    w_seg_idx_nxt = r_seg_idx + 3'd1;
                    w_seg_cnt_nxt = SEG_W'(1);
                end else if (!w_timeout) begin
                    w_seg_cnt_nxt = r_seg_cnt + SEG_W'(1);
                end
            end
            S_DONE: begin
                if (w_quot_ovf) begin
                    w_error_nxt = 1'b1;
                end else begin
                    w_prescale_nxt   = 16'(w_quot);
                    w_locked_nxt     = 1'b1;
                    w_lock_pulse_nxt = 1'b1;
                end
            end
            S_FAIL:  w_error_nxt = 1'b1;
            default: ;
        endcase
        if (start) begin
            w_idle_cnt_nxt = '0;
            w_seg_cnt_nxt  = '0;
            w_first_nxt    = '0;
            w_total_nxt    = '0;
            w_seg_idx_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt   <= '0;
            r_seg_cnt    <= '0;
            r_first      <= '0;
            r_total      <= '0;
            r_seg_idx    <= '0;
            r_prescale   <= DEFAULT_PRESCALE;
            r_locked     <= 1'b0;
            r_lock_pulse <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_idle_cnt   <= w_idle_cnt_nxt;
            r_seg_cnt    <= w_seg_cnt_nxt;
            r_first      <= w_first_nxt;
            r_total      <= w_total_nxt;
            r_seg_idx    <= w_seg_idx_nxt;
            r_prescale   <= w_prescale_nxt;
            r_locked     <= w_locked_nxt;
            r_lock_pulse <= w_lock_pulse_nxt;
            r_error      <= w_error_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign prescale   = r_prescale;
    assign locked     = r_locked;
    assign lock_pulse = r_lock_pulse;
    assign error      = r_error;
    assign busy       = r_busy;

endmodule
